mem_page_writer: RTL
====================

MEM_PAGE_WRITER -- requirements
Module: mem_page_writer

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- RAM_WIDTH, 32, data word width.
- RAM_DEPTH, 16, entries per page; power of 2.
- PAGES, 2, pages per memory; power of 2, ≥ 2.
REQ-002 Derived widths SHALL be: AW = log2(RAM_DEPTH) + log2(PAGES); NW = log2(RAM_DEPTH) + 1.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- en_proc, in, 1: processing enable.
- bx_in, in, 3: current bunch-crossing number.
- din_valid, in, 1: input word valid.
- din, in, RAM_WIDTH: input word.
- wea, out, 1: BRAM port A write enable.
- addra, out, AW: write address, {page, index}.
- dina, out, RAM_WIDTH: write data.
- nent, out, PAGES*NW: per-page entry counts; page p occupies bits [p*NW +: NW].
- bx_out, out, 3: BX of the last completed page.
- done, out, 1: one-cycle pulse when a page completes.
- overflow, out, 1: sticky flag, set when the current BX dropped a word.
- ovf_cnt, out, 16: total dropped-word count.

Function
REQ-004 States SHALL be IDLE, ARMED and WRITE.
REQ-005 State transitions SHALL be:
- IDLE -> ARMED when en_proc=1.
- ARMED -> WRITE on the first BX change.
- Any state -> IDLE when en_proc=0.
REQ-006 The block SHALL register bx_in into bx_q every cycle. A BX change is the condition bx_in != bx_q.
REQ-007 Active page SHALL be bx_in mod PAGES, latched at each BX change.
REQ-008 On a BX change while in WRITE, the block SHALL do all of the following in the next cycle:
- clear the new page's count to 0;
- set bx_out to bx_q;
- pulse done for 1 cycle;
- clear overflow.
All other pages' counts SHALL hold.
REQ-009 On a BX change in ARMED, the block SHALL clear the new page's count and SHALL NOT pulse done.
REQ-010 In WRITE, a cycle with din_valid=1 and active count < RAM_DEPTH SHALL produce, one cycle later:
- wea=1;
- addra = {page, count};
- dina = din;
- active count incremented by 1.
REQ-011 Write latency SHALL be exactly 1 cycle. wea SHALL be 0 in every cycle with no accepted word.
REQ-012 If din_valid=1 and a BX change occur in the same cycle, the word SHALL belong to the new BX and SHALL be written at index 0 of the new page.
REQ-013 Full page: with count == RAM_DEPTH, a valid word SHALL be dropped (wea=0, count holds), overflow SHALL be set, and ovf_cnt SHALL increment per REQ-019.
REQ-014 din_valid SHALL be ignored in IDLE and in ARMED.
REQ-015 The nent field of a page SHALL update in the cycle its wea is asserted, so that it equals the number of words written so far.
REQ-016 bx_in wrap from 7 to 0 SHALL count as an ordinary BX change.

Reset
REQ-017 While reset=1, on the clock edge, the block SHALL set:
- state IDLE;
- wea 0, addra 0, dina 0;
- all nent 0;
- bx_out 0, done 0, overflow 0, ovf_cnt 0;
- bx_q = bx_in.
REQ-018 A reset asserted during WRITE SHALL abort the page. No wea SHALL be asserted in the cycle after the reset edge.

Configuration
REQ-019 With macro WRITER_OVF_CNT_EN defined, ovf_cnt SHALL count every dropped word, saturate at 16'hFFFF, and be cleared only by reset.
REQ-020 Without WRITER_OVF_CNT_EN, ovf_cnt SHALL be constant 0, no counter logic SHALL be present, and overflow behaviour SHALL be unchanged.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic write: reset, en_proc=1, bx 2->3, 5 valid words 0xA0..0xA4 -> writes at addra 0x10..0x14 (page 1), nent page1 = 5; bx 3->4 -> done pulse, bx_out=3, page0 count=0.
- Same-cycle BX change and data: din_valid with bx change 4->5, din=0x55 -> wea one cycle later at addra 0x10, dina 0x55, page1 count=1.
- Overflow: 18 valid words in one BX -> 16 writes (index 0..15), nent=16, overflow=1, ovf_cnt=2 (macro on) or 0 (macro off); next BX change -> overflow=0.
- Reset mid-page: reset after 3 writes -> next cycle wea=0, all nent=0, state IDLE; no write until ARMED sees a BX change.
- ARMED entry: en_proc rises mid-BX with din_valid=1 -> no writes until the first BX change, and no done on that first change.
- BX wrap: bx 7->0 -> done pulse, bx_out=7, page 0 cleared.

Source files
------------

// File: rtl/mem_page_writer.sv
// Writes BX-tagged input words into a paged BRAM port. Each write appears 1 cycle after it is accepted; there is no backpressure, so a valid word that arrives when the page is full is dropped.
// Define WRITER_OVF_CNT_EN to build the saturating dropped-word counter that drives ovf_cnt.
module mem_page_writer #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 16,
    parameter int PAGES     = 2,
    localparam int IW = $clog2(RAM_DEPTH),
    localparam int PW = $clog2(PAGES),
    localparam int AW = IW + PW,
    localparam int NW = IW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_proc,
    input  logic [2:0]            bx_in,
    input  logic                  din_valid,
    input  logic [RAM_WIDTH-1:0]  din,
    output logic                  wea,
    output logic [AW-1:0]         addra,
    output logic [RAM_WIDTH-1:0]  dina,
    output logic [PAGES*NW-1:0]   nent,
    output logic [2:0]            bx_out,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           ovf_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [NW-1:0] DEPTH_N = NW'(RAM_DEPTH);

    logic [1:0]           state_q, state_d;
    logic [2:0]           bx_q;
    logic [NW-1:0]        cnt_q [PAGES];
    logic [NW-1:0]        cnt_d [PAGES];
    logic                 wea_q, wea_d;
    logic [AW-1:0]        addra_q, addra_d;
    logic [RAM_WIDTH-1:0] dina_q, dina_d;
    logic [2:0]           bx_out_q, bx_out_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 bx_chg;
    logic                 in_write;
    logic                 accept;
    logic                 drop;
    logic [PW-1:0]        page;
    logic [NW-1:0]        cnt_eff;

    // bx_q tracks bx_in every cycle, so the active page is simply the low bits of bx_in.
    assign bx_chg   = (bx_in != bx_q);
    assign page     = bx_in[PW-1:0];
    assign in_write = en_proc && (state_q == WRITE);
    // A word arriving with a BX change belongs to the new page, so it sees an empty count.
    assign cnt_eff  = bx_chg ? '0 : cnt_q[page];
    assign accept   = in_write && din_valid && (cnt_eff < DEPTH_N);
    assign drop     = in_write && din_valid && !(cnt_eff < DEPTH_N);

    always_comb begin
        state_d = state_q;
        if (!en_proc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = bx_chg ? WRITE : ARMED;
                WRITE:   state_d = WRITE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        dina_d   = dina_q;
        done_d   = in_write && bx_chg;
        bx_out_d = bx_out_q;
        ovf_d    = ovf_q;
        if (en_proc && (state_q != IDLE) && bx_chg) begin
            cnt_d[page] = '0;
        end
        if (done_d) begin
            bx_out_d = bx_q;
            ovf_d    = 1'b0;
        end
        if (accept) begin
            wea_d       = 1'b1;
            addra_d     = {page, cnt_eff[IW-1:0]};
            dina_d      = din;
            cnt_d[page] = cnt_eff + NW'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        bx_q <= bx_in;
        if (reset) begin
            state_q  <= IDLE;
            wea_q    <= 1'b0;
            addra_q  <= '0;
            dina_q   <= '0;
            bx_out_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int p = 0; p < PAGES; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wea_q    <= wea_d;
            addra_q  <= addra_d;
            dina_q   <= dina_d;
            bx_out_q <= bx_out_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar p = 0; p < PAGES; p++) begin : g_nent
        assign nent[p*NW +: NW] = cnt_q[p];
    end

`ifdef WRITER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

    assign wea      = wea_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign bx_out   = bx_out_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
